// File: rtl/spi_slave_if_if.sv
// SPI wire bundle between a master (e.g. SPI_ctrl) and the spi_slave_if endpoint.
// cs is active low; miso is the only slave-driven wire.
interface spi_slave_if_if;
  logic cs;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output cs, output sck, output mosi, input miso);
  modport slave  (input cs, input sck, input mosi, output miso);
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave endpoint, all four modes, oversampled in the clk domain.
// cs/sck/mosi go through 2-FF synchronisers; sck edges come from a third
// register. One word of transmit buffering; received words are presented
// on rx_data with a one-cycle rx_valid pulse.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  spi_slave_if_if.slave     bus,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [1:0]        cs_s;
  logic [2:0]        sck_s;
  logic [1:0]        mosi_s;
  logic [1:0]        sync_ok;
  logic              cs_armed;

  logic [1:0]        mode_q;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_buf;

  logic enter;
  logic sck_rise, sck_fall;
  logic smp_edge, shf_edge;
  logic last_bit, reload, do_load;

  // Two-stage synchronisers; sck gets a third stage for edge detection.
  // Reset values model an idle bus: cs high, sck low, mosi low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s    <= 2'b11;
      sck_s   <= 3'b000;
      mosi_s  <= 2'b00;
      sync_ok <= 2'b00;
    end else begin
      cs_s    <= {cs_s[0], bus.cs};
      sck_s   <= {sck_s[1:0], bus.sck};
      mosi_s  <= {mosi_s[0], bus.mosi};
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  // A transfer may start only after cs has been seen high through a
  // settled synchroniser, so a cs held low across reset cannot re-enter.
  always_ff @(posedge clk) begin
    if (rst)
      cs_armed <= 1'b0;
    else if (enter)
      cs_armed <= 1'b0;
    else if (state_q == IDLE && sync_ok[1] && cs_s[1])
      cs_armed <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: enter on cs low once armed, leave as soon as cs is high.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_armed && !cs_s[1]) begin
          state_d = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge classification from the latched mode: sample on rising when
  // CPOL==CPHA, shift on the other edge. Edges are ignored in the cycle
  // cs is seen high so an aborted word never completes.
  always_comb begin
    sck_rise = sck_s[1] & ~sck_s[2];
    sck_fall = ~sck_s[1] & sck_s[2];
    smp_edge = 1'b0;
    shf_edge = 1'b0;
    if (state_q == ACTIVE && !cs_s[1]) begin
      if (mode_q[1] == mode_q[0]) begin
        smp_edge = sck_rise;
        shf_edge = sck_fall;
      end else begin
        smp_edge = sck_fall;
        shf_edge = sck_rise;
      end
    end
    last_bit = smp_edge && (bit_cnt == LAST);
    reload   = enter || last_bit;
    do_load  = tx_load && tx_ready;
  end

  // Mode latch and bit counter; a partial word is dropped on cs rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= 2'b00;
      bit_cnt <= '0;
    end else if (enter) begin
      mode_q  <= mode;
      bit_cnt <= '0;
    end else if (state_q == ACTIVE && cs_s[1]) begin
      bit_cnt <= '0;
    end else if (smp_edge) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  // Receive shifter; the completed word is published on the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (smp_edge) begin
        rx_sr <= {rx_sr[DATA_W-2:0], mosi_s[1]};
        if (last_bit) begin
          rx_data  <= {rx_sr[DATA_W-2:0], mosi_s[1]};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit shifter. Reload at each word start; the first shift edge of a
  // word (bit_cnt==0) holds so the MSB stays on miso until it is sampled.
  always_ff @(posedge clk) begin
    if (rst)
      tx_sr <= '0;
    else if (reload)
      tx_sr <= tx_ready ? '0 : tx_buf;
    else if (shf_edge && bit_cnt != '0)
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
  end

  // Transmit buffer. A reload drains it (or flags underrun when empty); a
  // same-cycle load is applied afterwards so the new word stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (reload) begin
        tx_ready <= 1'b1;
        underrun <= tx_ready;
      end
      if (do_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  assign bus.miso = (state_q == ACTIVE) ? tx_sr[DATA_W-1] : 1'b1;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a behavioural SPI master drives the wires
// at clk/8 and every result is compared with a hand-computed value.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       cs, sck, mosi;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_load, tx_ready, busy, underrun;

  int n_chk  = 0;
  int n_pass = 0;

  int rxv_cnt    = 0;
  int ur_cnt     = 0;
  int ur_at_rxv  = 0;
  logic busy_mid = 1'b0;

  spi_slave_if_if bus ();
  assign bus.cs   = cs;
  assign bus.sck  = sck;
  assign bus.mosi = mosi;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .bus      (bus.slave),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Pulse monitor; ur_at_rxv holds the underrun count seen before the
  // cycle of the most recent rx_valid.
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt   = rxv_cnt + 1;
      ur_at_rxv = ur_cnt;
    end
    if (underrun) ur_cnt = ur_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  // Master: nbits MSB-first from dout[nbits-1:0], half-period 4 clk.
  task automatic spi_xfer(input logic [1:0] m, input logic [23:0] dout, input int nbits,
                          input bit end_cs, output logic [23:0] din);
    logic cpha;
    cpha = m[0];
    din  = '0;
    mode = m;
    sck  = m[1];
    tick(4);
    cs = 1'b0;
    if (!cpha) mosi = dout[nbits-1];
    tick(6);
    for (int b = nbits - 1; b >= 0; b--) begin
      if (cpha) begin
        mosi = dout[b];
        sck  = ~sck;
        tick(4);
        din = {din[22:0], bus.miso};
        sck = ~sck;
        tick(4);
      end else begin
        din = {din[22:0], bus.miso};
        sck = ~sck;
        tick(4);
        sck = ~sck;
        if (b > 0) mosi = dout[b-1];
        tick(4);
      end
    end
    busy_mid = busy;
    if (end_cs) begin
      cs = 1'b1;
      tick(8);
    end
  endtask

  initial begin
    logic [23:0] r;
    int rv0, ur0;
    rst = 1'b1; mode = 2'd0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0;
    tick(3);

    chk("rst_miso",     32'(bus.miso), 32'd1);
    chk("rst_rx_data",  32'(rx_data),  32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    tick(4);

    // Mode 0 basic exchange
    load(8'hA5);
    chk("m0_ready_after_load", 32'(tx_ready), 32'd0);
    rv0 = rxv_cnt;
    spi_xfer(2'd0, 24'h3C, 8, 1, r);
    chk("m0_master_rx", 32'(r[7:0]),    32'hA5);
    chk("m0_rx_data",   32'(rx_data),   32'h3C);
    chk("m0_rx_valid_n", 32'(rxv_cnt - rv0), 32'd1);
    chk("m0_busy_mid",  32'(busy_mid),  32'd1);
    chk("m0_tx_ready",  32'(tx_ready),  32'd1);
    chk("m0_busy_end",  32'(busy),      32'd0);

    // All four modes
    for (int m = 0; m < 4; m++) begin
      load(8'h5A);
      rv0 = rxv_cnt;
      spi_xfer(m[1:0], 24'h96, 8, 1, r);
      chk($sformatf("mode%0d_master_rx", m), 32'(r[7:0]),  32'h5A);
      chk($sformatf("mode%0d_rx_data", m),   32'(rx_data), 32'h96);
      chk($sformatf("mode%0d_rx_valid_n", m), 32'(rxv_cnt - rv0), 32'd1);
    end

    // Back-to-back words with underrun
    load(8'h11);
    rv0 = rxv_cnt;
    ur0 = ur_cnt;
    spi_xfer(2'd0, 24'hC35AE7, 24, 1, r);
    chk("b2b_miso_stream", 32'(r),               32'h110000);
    chk("b2b_rx_valid_n",  32'(rxv_cnt - rv0),   32'd3);
    chk("b2b_underrun_n",  32'(ur_at_rxv - ur0), 32'd2);
    chk("b2b_rx_data",     32'(rx_data),         32'hE7);

    // Abort after 5 bits, then a full word
    rv0 = rxv_cnt;
    spi_xfer(2'd0, 24'h15, 5, 1, r);
    chk("abort_busy_mid",   32'(busy_mid),      32'd1);
    chk("abort_rx_valid_n", 32'(rxv_cnt - rv0), 32'd0);
    chk("abort_busy_end",   32'(busy),          32'd0);
    chk("abort_rx_data",    32'(rx_data),       32'hE7);
    rv0 = rxv_cnt;
    spi_xfer(2'd0, 24'hF0, 8, 1, r);
    chk("post_abort_rx_data",   32'(rx_data),       32'hF0);
    chk("post_abort_rx_valid_n", 32'(rxv_cnt - rv0), 32'd1);

    // Reset at bit 3 with cs still low
    spi_xfer(2'd0, 24'h5, 3, 0, r);
    load(8'h99);
    chk("pre_rst_busy",     32'(busy),     32'd1);
    chk("pre_rst_tx_ready", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_miso",     32'(bus.miso), 32'd1);
    chk("mid_rst_rx_data",  32'(rx_data),  32'h0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    tick(10);
    chk("no_reentry_busy", 32'(busy), 32'd0);
    cs = 1'b1;
    tick(8);
    load(8'h81);
    rv0 = rxv_cnt;
    spi_xfer(2'd0, 24'h42, 8, 1, r);
    chk("post_rst_master_rx", 32'(r[7:0]),       32'h81);
    chk("post_rst_rx_data",   32'(rx_data),      32'h42);
    chk("post_rst_rx_valid_n", 32'(rxv_cnt - rv0), 32'd1);

    // Load collision: 0x77 arrives while 0x22 is pending
    load(8'h22);
    load(8'h77);
    chk("coll_tx_ready", 32'(tx_ready), 32'd0);
    spi_xfer(2'd1, 24'h00, 8, 1, r);
    chk("coll_master_rx", 32'(r[7:0]),  32'h22);
    chk("coll_rx_data",   32'(rx_data), 32'h00);
    chk("coll_tx_ready_end", 32'(tx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
